// File: rtl/rew_aes_cmd_scheduler_if.sv
// Signal bundle between a path-command source, the rew_aes_cmd_scheduler and the
// RO/RW command channels of the REW AES core.
//
// Handshake rule for every channel in this bundle (Cmd, RO, RW):
//   A transfer happens on a rising clock edge where valid and ready are both 1.
//   Once valid is raised, it and its payload hold steady until that transfer.
//   Ready may change freely and never depends combinationally on valid.
//
// The slave modport is the scheduler; the master modport is the environment
// (command source plus core).
interface rew_aes_cmd_scheduler_if #(
    parameter int ORAML          = 31,
    parameter int IVEntropyWidth = 64,
    parameter int BIDWidth       = ORAML + 1,
    parameter int PCCMDWidth     = 2
);
    // Path command channel
    logic [ORAML-1:0]          CmdLeaf;
    logic [IVEntropyWidth-1:0] CmdIV;
    logic [1:0]                CmdType;
    logic                      CmdValid;
    logic                      CmdReady;

    // RO command channel
    logic [IVEntropyWidth-1:0] ROIVOut;
    logic [BIDWidth-1:0]       ROBIDOut;
    logic [PCCMDWidth-1:0]     ROCommandOut;
    logic                      ROCommandOutValid;
    logic                      ROCommandOutReady;

    // RW command channel
    logic [IVEntropyWidth-1:0] RWIVOut;
    logic [BIDWidth-1:0]       RWBIDOut;
    logic                      RWCommandOutValid;
    logic                      RWCommandOutReady;

    // Status
    logic                      Busy;
    logic                      DonePulse;
    logic                      ErrorPulse;
    logic [1:0]                DebugState;

    modport slave (
        input  CmdLeaf, CmdIV, CmdType, CmdValid,
        input  ROCommandOutReady, RWCommandOutReady,
        output CmdReady,
        output ROIVOut, ROBIDOut, ROCommandOut, ROCommandOutValid,
        output RWIVOut, RWBIDOut, RWCommandOutValid,
        output Busy, DonePulse, ErrorPulse, DebugState
    );

    modport master (
        output CmdLeaf, CmdIV, CmdType, CmdValid,
        output ROCommandOutReady, RWCommandOutReady,
        input  CmdReady,
        input  ROIVOut, ROBIDOut, ROCommandOut, ROCommandOutValid,
        input  RWIVOut, RWBIDOut, RWCommandOutValid,
        input  Busy, DonePulse, ErrorPulse, DebugState
    );
endinterface

// File: rtl/rew_aes_cmd_scheduler.sv
// Path-level command sequencer for the REW AES core. One ORAM path operation
// (leaf, IV, type) is expanded into ORAML+1 bucket commands, one per tree level,
// issued on the RO channel (read headers / read data) or the RW channel (write).
// Bucket IDs use heap numbering: root 0, children of n are 2n+1 and 2n+2.
//
// Build option: define REWAES_SCHED_LEAF_FIRST_EN to issue buckets leaf-first
// (level ORAML down to 0); otherwise buckets go root-first (level 0 up to ORAML).
module rew_aes_cmd_scheduler #(
    parameter int ORAML          = 31,
    parameter int IVEntropyWidth = 64,
    parameter int BIDWidth       = ORAML + 1,
    parameter int PCCMDWidth     = 2
) (
    input  logic                   Clock,
    input  logic                   Reset,
    rew_aes_cmd_scheduler_if.slave bus
);
    // RO command encodings as used by the core (REWAESLocal.vh)
    localparam logic [PCCMDWidth-1:0] PCMD_ROHeader = PCCMDWidth'(0);
    localparam logic [PCCMDWidth-1:0] PCMD_ROData   = PCCMDWidth'(1);

    localparam int LW = (ORAML < 1) ? 1 : $clog2(ORAML + 1);

`ifdef REWAES_SCHED_LEAF_FIRST_EN
    localparam logic [LW-1:0] START_LVL = LW'(ORAML);
    localparam logic [LW-1:0] LAST_LVL  = '0;
`else
    localparam logic [LW-1:0] START_LVL = '0;
    localparam logic [LW-1:0] LAST_LVL  = LW'(ORAML);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [LW-1:0]             level, level_next;
    logic [ORAML-1:0]          leaf;
    logic [1:0]                op_type;
    logic [IVEntropyWidth-1:0] iv_q;
    logic [BIDWidth-1:0]       bid_q;
    logic [PCCMDWidth-1:0]     cmd_q;
    logic                      ro_valid, rw_valid;
    logic                      out_ready, accept, fire, is_last;
    logic [ORAML-1:0]          leaf_src;

    // Bucket on the path to leaf lf at level lvl: (2^lvl - 1) + (lf >> (ORAML - lvl)).
    // The sum always fits in BIDWidth bits, so no overflow handling is needed.
    function automatic logic [BIDWidth-1:0] bucket_id(input logic [LW-1:0] lvl,
                                                      input logic [ORAML-1:0] lf);
        logic [BIDWidth-1:0] base;
        logic [BIDWidth-1:0] offset;
        base   = (BIDWidth'(1) << lvl) - BIDWidth'(1);
        offset = BIDWidth'(lf) >> (ORAML - int'(lvl));
        return base + offset;
    endfunction

    // Ready of whichever channel the current operation targets
    assign out_ready = (op_type == 2'd2) ? bus.RWCommandOutReady : bus.ROCommandOutReady;
    assign is_last   = (level == LAST_LVL);
    // On acceptance the leaf register is not loaded yet, so take the incoming one
    assign leaf_src  = accept ? bus.CmdLeaf : leaf;

    // Next-state and level-counter logic
    always_comb begin
        state_next = state;
        level_next = level;
        accept     = 1'b0;
        fire       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.CmdValid) begin
                    accept     = 1'b1;
                    level_next = START_LVL;
                    state_next = (bus.CmdType == 2'd3) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if ((ro_valid || rw_valid) && out_ready) begin
                    fire = 1'b1;
                    if (is_last) begin
                        state_next = ST_DONE;
                    end else begin
`ifdef REWAES_SCHED_LEAF_FIRST_EN
                        level_next = level - LW'(1);
`else
                        level_next = level + LW'(1);
`endif
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state and level counter registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            level <= '0;
        end else begin
            state <= state_next;
            level <= level_next;
        end
    end

    // Latched operation, registered channel payload and valids
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            leaf     <= '0;
            op_type  <= '0;
            iv_q     <= '0;
            bid_q    <= '0;
            cmd_q    <= '0;
            ro_valid <= 1'b0;
            rw_valid <= 1'b0;
        end else begin
            if (accept) begin
                leaf     <= bus.CmdLeaf;
                op_type  <= bus.CmdType;
                iv_q     <= bus.CmdIV;
                cmd_q    <= (bus.CmdType == 2'd1) ? PCMD_ROData : PCMD_ROHeader;
                ro_valid <= (bus.CmdType == 2'd0) || (bus.CmdType == 2'd1);
                rw_valid <= (bus.CmdType == 2'd2);
            end else if (fire && is_last) begin
                ro_valid <= 1'b0;
                rw_valid <= 1'b0;
            end
            // Payload only moves on acceptance or a non-final handshake, so it
            // stays frozen while the core stalls
            if (accept || (fire && !is_last)) begin
                bid_q <= bucket_id(level_next, leaf_src);
            end
        end
    end

    assign bus.CmdReady          = (state == ST_IDLE);
    assign bus.Busy              = (state != ST_IDLE);
    assign bus.DonePulse         = (state == ST_DONE) && (op_type != 2'd3);
    assign bus.ErrorPulse        = (state == ST_DONE) && (op_type == 2'd3);
    assign bus.DebugState        = state;

    assign bus.ROIVOut           = iv_q;
    assign bus.ROBIDOut          = bid_q;
    assign bus.ROCommandOut      = cmd_q;
    assign bus.ROCommandOutValid = ro_valid;

    assign bus.RWIVOut           = iv_q;
    assign bus.RWBIDOut          = bid_q;
    assign bus.RWCommandOutValid = rw_valid;
endmodule

// File: tb/tb_rew_aes_cmd_scheduler.sv
// Directed bench for rew_aes_cmd_scheduler: ORAML=3 instance for the main
// scenarios and an ORAML=31 instance for the widest bucket ID. Honours the
// REWAES_SCHED_LEAF_FIRST_EN build option for the expected issue order.
module tb_rew_aes_cmd_scheduler;
`ifdef REWAES_SCHED_LEAF_FIRST_EN
    localparam bit LEAF_FIRST = 1'b1;
`else
    localparam bit LEAF_FIRST = 1'b0;
`endif
    localparam logic [1:0] PCMD_HDR = 2'd0;
    localparam logic [1:0] PCMD_DAT = 2'd1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Hand-computed bucket IDs, indexed by level, for ORAML=3
    int bids_leaf5 [4] = '{0, 2, 5, 12};
    int bids_leaf0 [4] = '{0, 1, 3, 7};

    rew_aes_cmd_scheduler_if #(.ORAML(3))  bus3 ();
    rew_aes_cmd_scheduler_if #(.ORAML(31)) bus31 ();

    rew_aes_cmd_scheduler #(.ORAML(3)) u_dut3 (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus3)
    );

    rew_aes_cmd_scheduler #(.ORAML(31)) u_dut31 (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus31)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Level issued at position pos of a path whose last level is last
    function automatic int level_at(input int pos, input int last);
        return LEAF_FIRST ? (last - pos) : pos;
    endfunction

    // Present one command to the ORAML=3 instance; returns just after the accepting edge
    task automatic send3(input logic [2:0] leaf, input logic [63:0] iv, input logic [1:0] typ);
        @(negedge clk);
        bus3.CmdLeaf  = leaf;
        bus3.CmdIV    = iv;
        bus3.CmdType  = typ;
        bus3.CmdValid = 1'b1;
        check("cmd_ready_before_accept", bus3.CmdReady, 1);
        @(posedge clk);
        #1 bus3.CmdValid = 1'b0;
    endtask

    // Observe a full 4-bucket path on bus3 with ready held high
    task automatic watch_path3(input string tag, input bit rw, input logic [1:0] cmd,
                               input logic [63:0] iv, input bit leaf5);
        int lvl;
        int exp_bid;
        for (int pos = 0; pos < 4; pos++) begin
            @(negedge clk);
            lvl     = level_at(pos, 3);
            exp_bid = leaf5 ? bids_leaf5[lvl] : bids_leaf0[lvl];
            check({tag, "_busy"}, bus3.Busy, 1);
            check({tag, "_cmd_ready"}, bus3.CmdReady, 0);
            if (rw) begin
                check({tag, "_rw_valid"}, bus3.RWCommandOutValid, 1);
                check({tag, "_ro_valid"}, bus3.ROCommandOutValid, 0);
                check({tag, "_rw_bid"}, bus3.RWBIDOut, exp_bid);
                check({tag, "_rw_iv"}, bus3.RWIVOut, iv);
            end else begin
                check({tag, "_ro_valid"}, bus3.ROCommandOutValid, 1);
                check({tag, "_rw_valid"}, bus3.RWCommandOutValid, 0);
                check({tag, "_ro_bid"}, bus3.ROBIDOut, exp_bid);
                check({tag, "_ro_cmd"}, bus3.ROCommandOut, cmd);
                check({tag, "_ro_iv"}, bus3.ROIVOut, iv);
            end
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, bus3.DonePulse, 1);
        check({tag, "_done_ro_valid"}, bus3.ROCommandOutValid, 0);
        check({tag, "_done_rw_valid"}, bus3.RWCommandOutValid, 0);
        check({tag, "_done_cmd_ready"}, bus3.CmdReady, 0);
        @(negedge clk);
        check({tag, "_idle_cmd_ready"}, bus3.CmdReady, 1);
        check({tag, "_idle_done_pulse"}, bus3.DonePulse, 0);
        check({tag, "_idle_busy"}, bus3.Busy, 0);
    endtask

    initial begin
        int lvl;
        bus3.CmdLeaf = '0;  bus3.CmdIV = '0;  bus3.CmdType = '0;  bus3.CmdValid = 1'b0;
        bus3.ROCommandOutReady = 1'b0;  bus3.RWCommandOutReady = 1'b0;
        bus31.CmdLeaf = '0; bus31.CmdIV = '0; bus31.CmdType = '0; bus31.CmdValid = 1'b0;
        bus31.ROCommandOutReady = 1'b0; bus31.RWCommandOutReady = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", bus3.CmdReady, 1);
        check("rst_busy", bus3.Busy, 0);
        check("rst_ro_valid", bus3.ROCommandOutValid, 0);
        check("rst_rw_valid", bus3.RWCommandOutValid, 0);
        check("rst_done", bus3.DonePulse, 0);
        check("rst_error", bus3.ErrorPulse, 0);
        check("rst_ro_bid", bus3.ROBIDOut, 0);
        check("rst_ro_iv", bus3.ROIVOut, 0);
        check("rst_ro_cmd", bus3.ROCommandOut, 0);
        check("rst_rw_bid", bus3.RWBIDOut, 0);
        check("rst_state", bus3.DebugState, 0);
        rst_n = 1'b1;

        // Read headers, leaf 5, no backpressure
        bus3.ROCommandOutReady = 1'b1;
        bus3.RWCommandOutReady = 1'b1;
        send3(3'd5, 64'h1234567812345678, 2'd0);
        watch_path3("hdr_leaf5", 1'b0, PCMD_HDR, 64'h1234567812345678, 1'b1);

        // Write path, leaf 5, RW channel only
        send3(3'd5, 64'hCAFEF00D00000001, 2'd2);
        watch_path3("wr_leaf5", 1'b1, PCMD_HDR, 64'hCAFEF00D00000001, 1'b1);

        // Read data, leaf 0, three stall cycles on level 1
        send3(3'd0, 64'h00000000DEADBEEF, 2'd1);
        for (int pos = 0; pos < 4; pos++) begin
            @(negedge clk);
            lvl = level_at(pos, 3);
            if (lvl == 1) begin
                bus3.ROCommandOutReady = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check("stall_valid", bus3.ROCommandOutValid, 1);
                    check("stall_bid", bus3.ROBIDOut, 1);
                    @(negedge clk);
                end
                bus3.ROCommandOutReady = 1'b1;
            end
            check("data_valid", bus3.ROCommandOutValid, 1);
            check("data_bid", bus3.ROBIDOut, bids_leaf0[lvl]);
            check("data_cmd", bus3.ROCommandOut, PCMD_DAT);
            check("data_rw_valid", bus3.RWCommandOutValid, 0);
        end
        @(negedge clk);
        check("data_done_pulse", bus3.DonePulse, 1);
        @(negedge clk);
        check("data_idle", bus3.CmdReady, 1);

        // Reserved type
        send3(3'd2, 64'h1, 2'd3);
        @(negedge clk);
        check("rsv_error_pulse", bus3.ErrorPulse, 1);
        check("rsv_done_pulse", bus3.DonePulse, 0);
        check("rsv_ro_valid", bus3.ROCommandOutValid, 0);
        check("rsv_rw_valid", bus3.RWCommandOutValid, 0);
        check("rsv_cmd_ready", bus3.CmdReady, 0);
        @(negedge clk);
        check("rsv_idle_cmd_ready", bus3.CmdReady, 1);
        check("rsv_error_cleared", bus3.ErrorPulse, 0);
        check("rsv_idle_ro_valid", bus3.ROCommandOutValid, 0);

        // Reset after two handshakes abandons the path
        send3(3'd5, 64'hABCD, 2'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_valid", bus3.ROCommandOutValid, 1);
        check("abort_pre_bid", bus3.ROBIDOut, bids_leaf5[level_at(2, 3)]);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ro_valid", bus3.ROCommandOutValid, 0);
        check("abort_rw_valid", bus3.RWCommandOutValid, 0);
        check("abort_busy", bus3.Busy, 0);
        check("abort_cmd_ready", bus3.CmdReady, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_done", bus3.DonePulse, 0);
        end
        send3(3'd0, 64'h55AA55AA55AA55AA, 2'd2);
        watch_path3("restart_wr_leaf0", 1'b1, PCMD_HDR, 64'h55AA55AA55AA55AA, 1'b0);

        // Full-depth instance, all-ones leaf
        bus31.ROCommandOutReady = 1'b1;
        @(negedge clk);
        bus31.CmdLeaf  = 31'h7FFFFFFF;
        bus31.CmdIV    = 64'h0F0F0F0F0F0F0F0F;
        bus31.CmdType  = 2'd0;
        bus31.CmdValid = 1'b1;
        check("o31_cmd_ready", bus31.CmdReady, 1);
        @(posedge clk);
        #1 bus31.CmdValid = 1'b0;
        for (int pos = 0; pos < 32; pos++) begin
            @(negedge clk);
            lvl = level_at(pos, 31);
            check("o31_valid", bus31.ROCommandOutValid, 1);
            if (lvl == 0)  check("o31_root_bid", bus31.ROBIDOut, 64'h0);
            if (lvl == 1)  check("o31_l1_bid", bus31.ROBIDOut, 64'h2);
            if (lvl == 31) check("o31_last_bid", bus31.ROBIDOut, 64'hFFFFFFFE);
        end
        @(negedge clk);
        check("o31_done_pulse", bus31.DonePulse, 1);
        check("o31_done_valid", bus31.ROCommandOutValid, 0);
        @(negedge clk);
        check("o31_idle", bus31.CmdReady, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rew_aes_cmd_scheduler.md
# rew_aes_cmd_scheduler

Path-level command sequencer in front of the REW AES core. It accepts one ORAM path operation at a time, given as a leaf, an IV and an operation type. It expands that operation into ORAML+1 per-bucket commands, one per tree level, and drives them onto the core's RO command channel or RW command channel with valid/ready handshakes. Bucket IDs use heap numbering: root = 0, children of n = 2n+1 and 2n+2.

## Interface
Parameters:
- ORAML, 31, tree depth; a path has ORAML+1 buckets
- IVEntropyWidth, 64, IV width
- BIDWidth, ORAML+1, bucket ID width
- PCCMDWidth, 2, RO command width; encodings are PCMD_ROHeader and PCMD_ROData from REWAESLocal.vh

Ports:
- Clock  in  1  single clock
- Reset  in  1  asynchronous, active-low reset
- CmdLeaf  in  ORAML  leaf index of the path
- CmdIV  in  IVEntropyWidth  IV applied to every bucket of the path
- CmdType  in  2  0=ReadHeaders, 1=ReadData, 2=WritePath, 3=reserved
- CmdValid  in  1  command request
- CmdReady  out  1  high only in Idle
- ROIVOut  out  IVEntropyWidth  RO channel IV
- ROBIDOut  out  BIDWidth  RO channel bucket ID
- ROCommandOut  out  PCCMDWidth  RO channel command
- ROCommandOutValid  out  1  RO channel valid
- ROCommandOutReady  in  1  RO channel ready, from core
- RWIVOut  out  IVEntropyWidth  RW channel IV
- RWBIDOut  out  BIDWidth  RW channel bucket ID
- RWCommandOutValid  out  1  RW channel valid
- RWCommandOutReady  in  1  RW channel ready, from core
- Busy  out  1  high whenever not in Idle
- DonePulse  out  1  one-cycle pulse when a path finishes
- ErrorPulse  out  1  one-cycle pulse when a reserved type is accepted

## Operation
- FSM states: Idle, Issue, Done.
- Idle:
  - CmdReady=1.
  - On CmdValid&CmdReady, latch CmdLeaf, CmdIV and CmdType, and clear the level counter.
  - Type 3 → go to Done with ErrorPulse set; no channel activity.
  - Any other type → go to Issue.
- Issue: present one bucket command at a time on the selected channel.
  - Type 0 → RO channel, command PCMD_ROHeader.
  - Type 1 → RO channel, command PCMD_ROData.
  - Type 2 → RW channel.
  - The unselected channel's valid stays 0 for the whole operation.
- Bucket ID at level l: BID = (2^l − 1) + (Leaf >> (ORAML − l)).
  - Computed at BIDWidth bits; no overflow is possible.
  - The level counter is ceil(log2(ORAML+1)) bits and runs 0..ORAML.
- The counter advances only on output valid&ready.
  - Handshake on the last level (counter = ORAML) → go to Done.
  - The counter never wraps.
- Done: DonePulse=1 for one cycle, or ErrorPulse=1 for one cycle for type 3, then return to Idle.
- Output payload (IV, BID, command) is registered and stable while valid=1 and ready=0.
- Valid never drops without a handshake, except on reset.
- No queueing: a new command is accepted only in Idle, in the cycle after Done.

## Timing
- Reset values: CmdReady=1; every valid=0; Busy=0; DonePulse=0; ErrorPulse=0; every payload output=0; state Idle.
- Reset is asynchronous assert, synchronous release. Reset asserted mid-path drops every valid immediately and abandons the path; there is no DonePulse.
- Command accepted at clock edge N:
  - The first bucket valid is high from N+1.
  - Busy is high from N+1.
  - CmdReady is low from N+1.
- Throughput is one bucket per cycle with ready held high. A full path takes ORAML+1 cycles of valid.
- The last handshake at edge M gives DonePulse high in cycle M+1 and CmdReady=1 in cycle M+2.
- Reserved type accepted at edge N: ErrorPulse high in cycle N+1, Idle again at N+2.
- Ready may toggle freely; each stall holds the current bucket unchanged.

## Configuration
- REWAES_SCHED_LEAF_FIRST_EN defined: buckets are issued leaf-first, level ORAML down to 0. The counter starts at ORAML and the last handshake is at level 0.
- Undefined: buckets are issued root-first, level 0 up to ORAML.
- Handshake, latency and pulse behaviour are identical in both builds.

## Test plan
All scenarios use ORAML=3 unless stated.
- Root-first BIDs: Leaf=5, Type=0, IV=64'h1234567812345678, ready held 1 → RO BIDs 0, 2, 5, 12 on 4 consecutive cycles, all PCMD_ROHeader, all with IV 64'h1234567812345678. DonePulse follows one cycle after the BID-12 handshake.
- Build with REWAES_SCHED_LEAF_FIRST_EN, Leaf=5, Type=2 → RW BIDs 12, 5, 2, 0. RO valid stays 0 throughout.
- Backpressure: Type=1, Leaf=0, ready low for 3 cycles on level 1 → BID 1 is held stable with valid high for 4 cycles, then BIDs 3 and 7 follow.
- Reserved type: Type=3 → ErrorPulse for one cycle, no valid on either channel, CmdReady back to 1 two cycles after acceptance.
- Reset during Issue after two handshakes → all valids 0 in the same cycle, no DonePulse. A new command then restarts at level 0.
- ORAML=31, Leaf=31'h7FFFFFFF → last BID equals 32'hFFFFFFFE.
